hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4: maximum long-latency writes in flight (1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 issue_valid  input  1  ID stage presents an instruction this cycle.
REQ-005 issue_long  input  1  instruction is a long-latency producer (load, mul/div) whose result arrives via wb port.
REQ-006 issue_reg_write  input  1  instruction writes rd.
REQ-007 issue_rd_addr  input  5  destination register.
REQ-008 issue_rs1_addr, issue_rs2_addr  input  5 each  source registers.
REQ-009 issue_uses_rs1, issue_uses_rs2  input  1 each  source actually read.
REQ-010 wb_valid  input  1  a long-latency result is written back this cycle.
REQ-011 wb_rd_addr  input  5  register being written back.
REQ-012 flush  input  1  pipeline flush; instruction in ID is discarded.
REQ-013 stall  output  1  combinational; hold ID/IF this cycle.
REQ-014 issue_accept  output  1  combinational; instruction leaves ID this cycle.
REQ-015 pending_mask  output  32  registered; bit n = x(n) awaits a long-latency write.
REQ-016 outstanding  output  3  registered; count of long-latency writes in flight.
REQ-017 stall_count  output  16  registered; saturating count of stall cycles.

Function
REQ-018 Tracked issue (trk) SHALL = issue_valid & issue_long & issue_reg_write & (issue_rd_addr != 0).
REQ-019 RAW hazard SHALL = (uses_rs1 & rs1 != 0 & pending_mask[rs1]) | (uses_rs2 & rs2 != 0 & pending_mask[rs2]), evaluated against registered mask (no same-cycle wb bypass into stall).
REQ-020 WAW hazard SHALL = issue_valid & issue_reg_write & rd != 0 & pending_mask[rd].
REQ-021 Full hazard SHALL = trk & (outstanding == MAX_OUTSTANDING).
REQ-022 stall SHALL = issue_valid & !flush & (RAW | WAW | full).
REQ-023 issue_accept SHALL = issue_valid & !flush & !stall.
REQ-024 On issue_accept & trk: pending_mask[rd] set and outstanding incremented at next edge.
REQ-025 On wb_valid with wb_rd_addr != 0 and pending_mask[wb_rd_addr] set: bit cleared and outstanding decremented at next edge.
REQ-026 wb_valid to a non-pending register or x0 SHALL be ignored (no mask/count change).
REQ-027 Simultaneous accepted trk issue and wb in same cycle: outstanding net unchanged; if same register (impossible under REQ-020 but defensively) set SHALL win.
REQ-028 outstanding SHALL always equal popcount(pending_mask); never exceed MAX_OUTSTANDING, never underflow.
REQ-029 pending_mask[0] SHALL be constant 0.
REQ-030 flush SHALL NOT clear pending bits; in-flight long operations complete and write back normally.
REQ-031 stall_count increments on every cycle with stall = 1; saturates at 16'hFFFF.
REQ-032 Latency: hazard cleared by wb in cycle N lifts stall in cycle N+1.

Reset
REQ-033 While rst high: pending_mask = 0, outstanding = 0, stall_count = 0, asynchronously, regardless of clk.
REQ-034 Reset mid-operation SHALL drop all pending entries; subsequent wb_valid to dropped registers ignored per REQ-026.
REQ-035 stall/issue_accept SHALL follow REQ-022/023 combinationally during reset using the cleared mask.

Verification
REQ-036 Reset, issue load rd=5, next cycle issue add rs1=5 -> stall=1, pending_mask=0x20, outstanding=1; wb rd=5 -> next cycle stall=0, mask=0, stall_count=1 per stall cycle.
REQ-037 Issue four loads rd=1..4 (MAX=4), fifth load rd=6 -> stall=1 (full); wb rd=2 -> fifth accepted next cycle, outstanding returns to 4, mask=0x5A.
REQ-038 Load rd=7 pending, issue long op rd=7 -> WAW stall; issue with rd=0 or rs=0 -> never stalls, mask unchanged.
REQ-039 Same cycle: accept load rd=3 and wb rd=9 (pending) -> outstanding unchanged, mask bit3 set, bit9 clear.
REQ-040 flush=1 with hazardous instruction -> stall=0, issue_accept=0, mask unchanged; rst asserted mid-clock with 3 pending -> mask=0, outstanding=0 immediately.
REQ-041 Hold stall for 70000 cycles -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage issue, long-latency writeback and scoreboard status bundle.
interface hazard_scoreboard_if;
  logic        issue_valid;
  logic        issue_long;
  logic        issue_reg_write;
  logic [4:0]  issue_rd_addr;
  logic [4:0]  issue_rs1_addr;
  logic [4:0]  issue_rs2_addr;
  logic        issue_uses_rs1;
  logic        issue_uses_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        flush;
  logic        stall;
  logic        issue_accept;
  logic [31:0] pending_mask;
  logic [2:0]  outstanding;
  logic [15:0] stall_count;
  modport master (
    output issue_valid, issue_long, issue_reg_write, issue_rd_addr, issue_rs1_addr, issue_rs2_addr,
           issue_uses_rs1, issue_uses_rs2, wb_valid, wb_rd_addr, flush,
    input  stall, issue_accept, pending_mask, outstanding, stall_count
  );
  modport slave (
    input  issue_valid, issue_long, issue_reg_write, issue_rd_addr, issue_rs1_addr, issue_rs2_addr,
           issue_uses_rs1, issue_uses_rs2, wb_valid, wb_rd_addr, flush,
    output stall, issue_accept, pending_mask, outstanding, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks long-latency destination registers and stalls ID on RAW/WAW/full hazards.
module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic             clk,
  input logic             rst,
  hazard_scoreboard_if.slave bus
);
  logic [31:0] r_mask;
  logic [2:0]  r_out;
  logic [15:0] r_cnt;
  logic        w_trk, w_raw, w_waw, w_full, w_stall, w_set, w_clr;
  logic [31:0] w_mask;
  always_comb begin
    w_trk   = bus.issue_valid & bus.issue_long & bus.issue_reg_write & (bus.issue_rd_addr != 5'd0);
    w_raw   = (bus.issue_uses_rs1 & (bus.issue_rs1_addr != 5'd0) & r_mask[bus.issue_rs1_addr]) |
              (bus.issue_uses_rs2 & (bus.issue_rs2_addr != 5'd0) & r_mask[bus.issue_rs2_addr]);
    w_waw   = bus.issue_valid & bus.issue_reg_write & (bus.issue_rd_addr != 5'd0) & r_mask[bus.issue_rd_addr];
    w_full  = w_trk & (r_out == 3'(MAX_OUTSTANDING));
    w_stall = bus.issue_valid & ~bus.flush & (w_raw | w_waw | w_full);
    w_set   = bus.issue_valid & ~bus.flush & ~w_stall & w_trk;
    w_clr   = bus.wb_valid & (bus.wb_rd_addr != 5'd0) & r_mask[bus.wb_rd_addr];
    // clear before set so a same-register collision leaves the bit pending
    w_mask  = ((r_mask & ~(w_clr ? 32'd1 << bus.wb_rd_addr : 32'd0)) |
               (w_set ? 32'd1 << bus.issue_rd_addr : 32'd0)) & ~32'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_out  <= '0;
      r_cnt  <= '0;
    end else begin
      r_mask <= w_mask;
      r_out  <= r_out + 3'(w_set) - 3'(w_clr);
      r_cnt  <= r_cnt + 16'(w_stall & ~&r_cnt);
    end
  end
  assign bus.stall        = w_stall;
  assign bus.issue_accept = bus.issue_valid & ~bus.flush & ~w_stall;
  assign bus.pending_mask = r_mask;
  assign bus.outstanding  = r_out;
  assign bus.stall_count  = r_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table, reset corners, randomized model check and counter saturation.
module tb_hazard_scoreboard;
  localparam int MAX = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  hazard_scoreboard_if bus();
  hazard_scoreboard #(.MAX_OUTSTANDING(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int q[$];
  int sc;

  typedef struct {
    bit v, l, w;
    logic [4:0] rd, rs1, rs2;
    bit u1, u2, wbv;
    logic [4:0] wbrd;
    bit fl, st, acc;
    logic [31:0] mask;
    logic [2:0] out;
    logic [15:0] sc;
  } vec_t;
  vec_t tbl[24];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(bit v, bit l, bit w, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                        bit u1, bit u2, bit wbv, logic [4:0] wbrd, bit fl);
    bus.issue_valid = v; bus.issue_long = l; bus.issue_reg_write = w;
    bus.issue_rd_addr = rd; bus.issue_rs1_addr = rs1; bus.issue_rs2_addr = rs2;
    bus.issue_uses_rs1 = u1; bus.issue_uses_rs2 = u2;
    bus.wb_valid = wbv; bus.wb_rd_addr = wbrd; bus.flush = fl;
  endtask

  function automatic vec_t mk(bit v, bit l, bit w, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              bit u1, bit u2, bit wbv, logic [4:0] wbrd, bit fl, bit st, bit acc,
                              logic [31:0] mask, logic [2:0] out, logic [15:0] c);
    vec_t t;
    t.v = v; t.l = l; t.w = w; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.wbv = wbv; t.wbrd = wbrd; t.fl = fl; t.st = st; t.acc = acc; t.mask = mask; t.out = out; t.sc = c;
    return t;
  endfunction

  function automatic bit pend(int r);
    foreach (q[i]) if (q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] qmask();
    logic [31:0] m = '0;
    foreach (q[i]) m[q[i]] = 1'b1;
    return m;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    //            v  l  w  rd  rs1 rs2 u1 u2 wbv wbrd fl st acc mask       out sc
    tbl[0]  = mk(1, 1, 1, 5,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h20,   1, 0);
    tbl[1]  = mk(1, 0, 1, 8,  5,  0,  1, 0, 0,  0,   0, 1, 0, 32'h20,   1, 1);
    tbl[2]  = mk(1, 0, 1, 8,  5,  0,  1, 0, 1,  5,   0, 1, 0, 32'h00,   0, 2);
    tbl[3]  = mk(1, 0, 1, 8,  5,  0,  1, 0, 0,  0,   0, 0, 1, 32'h00,   0, 2);
    tbl[4]  = mk(1, 1, 1, 1,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h02,   1, 2);
    tbl[5]  = mk(1, 1, 1, 2,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h06,   2, 2);
    tbl[6]  = mk(1, 1, 1, 3,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h0E,   3, 2);
    tbl[7]  = mk(1, 1, 1, 4,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h1E,   4, 2);
    tbl[8]  = mk(1, 1, 1, 6,  0,  0,  0, 0, 0,  0,   0, 1, 0, 32'h1E,   4, 3);
    tbl[9]  = mk(1, 1, 1, 6,  0,  0,  0, 0, 1,  2,   0, 1, 0, 32'h1A,   3, 4);
    tbl[10] = mk(1, 1, 1, 6,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h5A,   4, 4);
    tbl[11] = mk(0, 0, 0, 0,  0,  0,  0, 0, 1,  1,   0, 0, 0, 32'h58,   3, 4);
    tbl[12] = mk(0, 0, 0, 0,  0,  0,  0, 0, 1,  3,   0, 0, 0, 32'h50,   2, 4);
    tbl[13] = mk(1, 1, 1, 7,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'hD0,   3, 4);
    tbl[14] = mk(1, 1, 1, 7,  0,  0,  0, 0, 0,  0,   0, 1, 0, 32'hD0,   3, 5);
    tbl[15] = mk(1, 0, 1, 7,  0,  0,  0, 0, 0,  0,   0, 1, 0, 32'hD0,   3, 6);
    tbl[16] = mk(1, 1, 1, 0,  0,  0,  1, 1, 0,  0,   0, 0, 1, 32'hD0,   3, 6);
    tbl[17] = mk(0, 0, 0, 0,  0,  0,  0, 0, 1,  9,   0, 0, 0, 32'hD0,   3, 6);
    tbl[18] = mk(0, 0, 0, 0,  0,  0,  0, 0, 1,  0,   0, 0, 0, 32'hD0,   3, 6);
    tbl[19] = mk(1, 1, 1, 9,  0,  0,  0, 0, 0,  0,   0, 0, 1, 32'h2D0,  4, 6);
    tbl[20] = mk(0, 0, 0, 0,  0,  0,  0, 0, 1,  4,   0, 0, 0, 32'h2C0,  3, 6);
    tbl[21] = mk(1, 1, 1, 3,  0,  0,  0, 0, 1,  9,   0, 0, 1, 32'hC8,   3, 6);
    tbl[22] = mk(1, 0, 1, 10, 6,  0,  1, 0, 0,  0,   1, 0, 0, 32'hC8,   3, 6);
    tbl[23] = mk(0, 0, 0, 0,  0,  0,  0, 0, 0,  0,   0, 0, 0, 32'hC8,   3, 6);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_mask", bus.pending_mask, 32'h0);
    check("rst_out", 32'(bus.outstanding), 32'h0);
    check("rst_sc", 32'(bus.stall_count), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      set_in(tbl[i].v, tbl[i].l, tbl[i].w, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
             tbl[i].u1, tbl[i].u2, tbl[i].wbv, tbl[i].wbrd, tbl[i].fl);
      #1;
      check($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tbl[i].st));
      check($sformatf("v%0d_accept", i), 32'(bus.issue_accept), 32'(tbl[i].acc));
      @(posedge clk); #1;
      check($sformatf("v%0d_mask", i), bus.pending_mask, tbl[i].mask);
      check($sformatf("v%0d_out", i), 32'(bus.outstanding), 32'(tbl[i].out));
      check($sformatf("v%0d_sc", i), 32'(bus.stall_count), 32'(tbl[i].sc));
    end

    // asynchronous reset between edges with three registers pending, hazardous issue on rs1=6
    set_in(1, 0, 1, 10, 6, 0, 1, 0, 0, 0, 0);
    #1;
    check("pre_rst_stall", 32'(bus.stall), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_mask", bus.pending_mask, 32'h0);
    check("mid_rst_out", 32'(bus.outstanding), 32'h0);
    check("mid_rst_sc", 32'(bus.stall_count), 32'h0);
    check("mid_rst_stall", 32'(bus.stall), 32'h0);
    check("mid_rst_accept", 32'(bus.issue_accept), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
    @(posedge clk); #1;
    check("dropped_wb_mask", bus.pending_mask, 32'h0);
    check("dropped_wb_out", 32'(bus.outstanding), 32'h0);

    pulse_reset();
    q.delete();
    sc = 0;
    for (int n = 0; n < 2000; n++) begin
      bit v, l, w, u1, u2, wbv, fl, trk, raw, waw, full, est, eacc;
      logic [4:0] rd, rs1, rs2, wbrd;
      v = $urandom_range(0, 9) < 8;
      l = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 9) < 8;
      u1 = $urandom_range(0, 1) == 1;
      u2 = $urandom_range(0, 1) == 1;
      fl = $urandom_range(0, 9) == 0;
      rd = 5'($urandom_range(0, 15));
      rs1 = 5'($urandom_range(0, 15));
      rs2 = 5'($urandom_range(0, 15));
      wbv = $urandom_range(0, 9) < 4;
      wbrd = (q.size() > 0 && $urandom_range(0, 3) != 0) ? 5'(q[$urandom_range(0, q.size() - 1)])
                                                         : 5'($urandom_range(0, 31));
      set_in(v, l, w, rd, rs1, rs2, u1, u2, wbv, wbrd, fl);
      trk = v && l && w && rd != 0;
      raw = (u1 && rs1 != 0 && pend(int'(rs1))) || (u2 && rs2 != 0 && pend(int'(rs2)));
      waw = v && w && rd != 0 && pend(int'(rd));
      full = trk && q.size() == MAX;
      est = v && !fl && (raw || waw || full);
      eacc = v && !fl && !est;
      #1;
      check("rnd_stall", 32'(bus.stall), 32'(est));
      check("rnd_accept", 32'(bus.issue_accept), 32'(eacc));
      @(posedge clk); #1;
      if (wbv && wbrd != 0)
        foreach (q[i]) if (q[i] == int'(wbrd)) begin q.delete(i); break; end
      if (eacc && trk && !pend(int'(rd))) q.push_back(int'(rd));
      if (est && sc < 65535) sc++;
      check("rnd_mask", bus.pending_mask, qmask());
      check("rnd_out", 32'(bus.outstanding), 32'(q.size()));
      check("rnd_sc", 32'(bus.stall_count), 32'(sc));
    end

    pulse_reset();
    set_in(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    set_in(1, 0, 1, 8, 5, 0, 1, 0, 0, 0, 0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_pre", 32'(bus.stall_count), 32'hFFFE);
    check("sat_stall", 32'(bus.stall), 32'h1);
    repeat (5000) @(posedge clk);
    #1;
    check("sat_hold", 32'(bus.stall_count), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
